// File: rtl/sev_seg_pkg.sv
// Shared types for the seven-segment display path.
package sev_seg_pkg;

   localparam int DIGITS = 4;

   typedef logic [3:0] hex4_t;

   // d3 is the leftmost digit.
   typedef struct packed {
      hex4_t d3;
      hex4_t d2;
      hex4_t d1;
      hex4_t d0;
   } disp_word_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } arb_state_t;

   // Splits a requester's 16-bit value into display digits, nibble 3 leftmost.
   function automatic disp_word_t to_disp(input logic [DIGITS*4-1:0] v);
      disp_word_t w;
      w.d3 = v[15:12];
      w.d2 = v[11:8];
      w.d1 = v[7:4];
      w.d0 = v[3:0];
      return w;
   endfunction

endpackage

// File: rtl/sev_seg_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   input  logic [NREQ-1:0]         mask_i,
   output logic                    valid_o,
   output logic [NREQ-1:0]         onehot_o,
   output logic [$clog2(NREQ)-1:0] index_o
);

   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0] eligible;
   logic            found;
   int              cand;

   // Walk ptr, ptr+1, ... modulo NREQ and stop at the first eligible requester.
   always_comb begin
      eligible = req_i & mask_i;
      found    = 1'b0;
      cand     = 0;
      onehot_o = '0;
      index_o  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr_i) + i) % NREQ;
         if (!found && eligible[cand]) begin
            found          = 1'b1;
            onehot_o[cand] = 1'b1;
            index_o        = IDX_W'(cand);
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/sev_seg_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell per grant.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no owner; gnt_o=0, digits hold their last value
//   ST_SHOW | one requester owns the display; dwell counter running or
//           | saturated at HOLD_CYCLES (saturated = handoff allowed)
module sev_seg_arbiter
   import sev_seg_pkg::*;
#(
   parameter  int NREQ        = 4,
   parameter  int HOLD_CYCLES = 100_000_000,
   localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_i,
   input  logic [NREQ*16-1:0] data_i,
   input  logic [NREQ-1:0]  ltr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [3:0]       in3_o,
   output logic [3:0]       in2_o,
   output logic [3:0]       in1_o,
   output logic [3:0]       in0_o,
   output logic             ltr_o,
   output logic             busy_o
);

   localparam int IDX_W = $clog2(NREQ);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] own_q, own_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   disp_word_t       disp_q, disp_d;
   logic             ltr_q, ltr_d;
   logic             busy_q, busy_d;

   logic             pick_valid;
   logic [NREQ-1:0]  pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic [NREQ-1:0]  pick_mask;
   logic             expired;
   logic             owner_req;
   logic [15:0]      owner_data;
   logic [15:0]      pick_data;

   // In IDLE everyone may win; at expiry the current owner is excluded so a
   // waiting requester always gets the handoff.
   always_comb begin
      pick_mask = (state_q == ST_SHOW) ? ~gnt_q : {NREQ{1'b1}};
   end

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .mask_i   (pick_mask),
      .valid_o  (pick_valid),
      .onehot_o (pick_onehot),
      .index_o  (pick_idx)
   );

   // Per-cycle views of the owner and of the arbitration winner.
   always_comb begin
      expired    = (cnt_q == CNT_W'(HOLD_CYCLES));
      owner_req  = req_i[own_q];
      owner_data = data_i[{own_q, 4'b0000} +: 16];
      pick_data  = data_i[{pick_idx, 4'b0000} +: 16];
   end

   // Next-state logic: grant, dwell counting, live reload, handoff and release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      disp_d  = disp_q;
      ltr_d   = ltr_q;
      busy_d  = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_SHOW;
               gnt_d   = pick_onehot;
               own_d   = pick_idx;
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
               ptr_d   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               disp_d  = to_disp(pick_data);
               ltr_d   = ltr_i[pick_idx];
            end
         end

         ST_SHOW: begin
            if (!expired) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (owner_req) begin
                  disp_d = to_disp(owner_data);
                  ltr_d  = ltr_i[own_q];
               end
            end else if (pick_valid) begin
               gnt_d  = pick_onehot;
               own_d  = pick_idx;
               cnt_d  = CNT_W'(1);
               ptr_d  = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               disp_d = to_disp(pick_data);
               ltr_d  = ltr_i[pick_idx];
            end else if (owner_req) begin
               // Counter stays saturated so a newcomer is served next cycle.
               disp_d = to_disp(owner_data);
               ltr_d  = ltr_i[own_q];
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything including the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         disp_q  <= '0;
         ltr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         disp_q  <= disp_d;
         ltr_q   <= ltr_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign in3_o  = disp_q.d3;
   assign in2_o  = disp_q.d2;
   assign in1_o  = disp_q.d1;
   assign in0_o  = disp_q.d0;
   assign ltr_o  = ltr_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_sev_seg_arbiter.sv
// Bench for sev_seg_arbiter with NREQ=4, HOLD_CYCLES=4.
module tb_sev_seg_arbiter;

   localparam int NREQ = 4;
   localparam int HOLD = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_i;
   logic [NREQ*16-1:0] data_i;
   logic [NREQ-1:0]   ltr_i;
   logic [NREQ-1:0]   gnt_o;
   logic [3:0]        in3_o, in2_o, in1_o, in0_o;
   logic              ltr_o;
   logic              busy_o;

   always #5 clk = ~clk;

   sev_seg_arbiter #(
      .NREQ        (NREQ),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_i),
      .data_i (data_i),
      .ltr_i  (ltr_i),
      .gnt_o  (gnt_o),
      .in3_o  (in3_o),
      .in2_o  (in2_o),
      .in1_o  (in1_o),
      .in0_o  (in0_o),
      .ltr_o  (ltr_o),
      .busy_o (busy_o)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] disp_now();
      return {in3_o, in2_o, in1_o, in0_o};
   endfunction

   // Behavioural model: owner index (-1 = nobody), cycles shown so far,
   // round-robin start position, and what the display currently shows.
   int          m_own;
   int          m_ptr;
   int          m_cnt;
   logic [15:0] m_disp;
   logic        m_ltr;

   function automatic int first_from(input int start, input int skip);
      for (int i = 0; i < NREQ; i++) begin
         int k;
         k = (start + i) % NREQ;
         if (k != skip && req_i[k]) return k;
      end
      return -1;
   endfunction

   task automatic m_show(input int k);
      m_disp = data_i[16*k +: 16];
      m_ltr  = ltr_i[k];
   endtask

   task automatic m_grant(input int k);
      m_own = k;
      m_cnt = 1;
      m_ptr = (k + 1) % NREQ;
      m_show(k);
   endtask

   always @(posedge clk or posedge rst) begin
      int k;
      if (rst) begin
         m_own  = -1;
         m_ptr  = 0;
         m_cnt  = 0;
         m_disp = '0;
         m_ltr  = 1'b0;
      end else if (m_own < 0) begin
         k = first_from(m_ptr, -1);
         if (k >= 0) m_grant(k);
      end else if (m_cnt < HOLD) begin
         m_cnt = m_cnt + 1;
         if (req_i[m_own]) m_show(m_own);
      end else begin
         k = first_from(m_ptr, m_own);
         if (k >= 0) m_grant(k);
         else if (req_i[m_own]) m_show(m_own);
         else m_own = -1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("model_gnt", 32'(gnt_o), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
         check("model_busy", 32'(busy_o), (m_own < 0) ? 32'd0 : 32'd1);
         check("model_digits", 32'(disp_now()), 32'(m_disp));
         check("model_ltr", 32'(ltr_o), 32'(m_ltr));
         check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
      end
   end

   initial begin
      rst    = 1'b1;
      req_i  = '0;
      data_i = '0;
      ltr_i  = '0;

      // Reset state
      #1;
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_digits", 32'(disp_now()), 32'h0);
      check("rst_ltr", 32'(ltr_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_gnt", 32'(gnt_o), 32'h0);
      check("idle_busy", 32'(busy_o), 32'h0);

      // Single request with live update
      req_i           = 4'b0010;
      data_i[31:16]   = 16'hBEEF;
      ltr_i[1]        = 1'b1;
      @(negedge clk);
      check("single_gnt", 32'(gnt_o), 32'h2);
      check("single_digits", 32'(disp_now()), 32'hBEEF);
      check("single_ltr", 32'(ltr_o), 32'h1);
      check("single_busy", 32'(busy_o), 32'h1);
      data_i[31:16] = 16'h1234;
      @(negedge clk);
      check("live_digits", 32'(disp_now()), 32'h1234);
      req_i = '0;
      ltr_i = '0;
      repeat (6) @(negedge clk);
      check("release_gnt", 32'(gnt_o), 32'h0);
      check("release_busy", 32'(busy_o), 32'h0);
      check("release_digits", 32'(disp_now()), 32'h1234);
      check("release_ltr", 32'(ltr_o), 32'h1);

      // Dwell enforcement and gapless handoff
      req_i         = 4'b0001;
      data_i[15:0]  = 16'hAAAA;
      @(negedge clk);
      check("dwell_gnt_c1", 32'(gnt_o), 32'h1);
      check("dwell_digits", 32'(disp_now()), 32'hAAAA);
      req_i          = 4'b0101;
      data_i[47:32]  = 16'h5555;
      for (int i = 2; i <= HOLD; i++) begin
         @(negedge clk);
         check("dwell_gnt_hold", 32'(gnt_o), 32'h1);
      end
      @(negedge clk);
      check("handoff_gnt", 32'(gnt_o), 32'h4);
      check("handoff_digits", 32'(disp_now()), 32'h5555);
      check("handoff_busy", 32'(busy_o), 32'h1);

      // Reset in the middle of SHOW
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_gnt", 32'(gnt_o), 32'h0);
      check("midrst_digits", 32'(disp_now()), 32'h0);
      check("midrst_ltr", 32'(ltr_o), 32'h0);
      check("midrst_busy", 32'(busy_o), 32'h0);
      req_i  = 4'b1111;
      data_i = {16'h3333, 16'h2222, 16'h1111, 16'h0A0A};
      ltr_i  = 4'b1010;
      @(negedge clk);
      rst = 1'b0;

      // Round-robin fairness from a reset pointer
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("rr_gnt", 32'(gnt_o), 32'd1 << ((i / HOLD) % NREQ));
         if (i == 4) check("rr_digits_r1", 32'(disp_now()), 32'h1111);
         if (i == 12) check("rr_ltr_r3", 32'(ltr_o), 32'h1);
      end
      req_i = '0;
      repeat (3) @(negedge clk);
      check("rr_release_gnt", 32'(gnt_o), 32'h0);

      // Early drop: display frozen until dwell ends
      ltr_i          = '0;
      req_i          = 4'b1000;
      data_i[63:48]  = 16'hCAFE;
      @(negedge clk);
      check("drop_gnt_c1", 32'(gnt_o), 32'h8);
      check("drop_digits_c1", 32'(disp_now()), 32'hCAFE);
      req_i          = '0;
      data_i[63:48]  = 16'h0F0F;
      ltr_i[3]       = 1'b1;
      for (int i = 2; i <= HOLD; i++) begin
         @(negedge clk);
         check("drop_gnt_hold", 32'(gnt_o), 32'h8);
         check("drop_frozen", 32'(disp_now()), 32'hCAFE);
      end
      @(negedge clk);
      check("drop_idle_gnt", 32'(gnt_o), 32'h0);
      check("drop_idle_busy", 32'(busy_o), 32'h0);
      check("drop_kept_digits", 32'(disp_now()), 32'hCAFE);
      check("drop_kept_ltr", 32'(ltr_o), 32'h0);

      // Drop with pending requester: handoff, never IDLE
      ltr_i         = '0;
      req_i         = 4'b0001;
      data_i[15:0]  = 16'h9876;
      @(negedge clk);
      check("dh_gnt_c1", 32'(gnt_o), 32'h1);
      req_i          = 4'b0010;
      data_i[31:16]  = 16'h4321;
      ltr_i[1]       = 1'b1;
      for (int i = 2; i <= HOLD; i++) begin
         @(negedge clk);
         check("dh_gnt_hold", 32'(gnt_o), 32'h1);
         check("dh_busy_hold", 32'(busy_o), 32'h1);
         check("dh_frozen", 32'(disp_now()), 32'h9876);
      end
      @(negedge clk);
      check("dh_gnt", 32'(gnt_o), 32'h2);
      check("dh_busy", 32'(busy_o), 32'h1);
      check("dh_digits", 32'(disp_now()), 32'h4321);
      check("dh_ltr", 32'(ltr_o), 32'h1);

      // Sole owner past expiry keeps live-updating; newcomer served next cycle
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         data_i[31:16] = 16'h4000 + 16'(i);
      end
      @(negedge clk);
      check("sat_live_digits", 32'(disp_now()), 32'h4005);
      check("sat_gnt", 32'(gnt_o), 32'h2);
      req_i          = 4'b0110;
      data_i[47:32]  = 16'h7777;
      @(negedge clk);
      check("sat_newcomer_gnt", 32'(gnt_o), 32'h4);
      check("sat_newcomer_digits", 32'(disp_now()), 32'h7777);

      req_i = '0;
      repeat (8) @(negedge clk);
      check("end_idle_gnt", 32'(gnt_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sev_seg_arbiter.md
Name: sev_seg_arbiter

Overview:
Shares the single 4-digit seven-segment display path between NREQ requesters. Each requester presents a 16-bit hex value and a letter-mode flag. The block grants the display round-robin with a minimum dwell time, and drives the nibble and ltr inputs of sev_seg_driver with registered outputs. It sits between the application blocks (counters, status monitors) and sev_seg_driver.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLD_CYCLES, 100_000_000, minimum dwell per grant in clk cycles (1 s at 100 MHz); must be >= 1
CNT_W, $clog2(HOLD_CYCLES+1), dwell counter width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
req_i  input  NREQ  per-requester display request, level-sensitive
data_i  input  NREQ*16  requester k value at [16k+15:16k]; nibble 3 = leftmost digit
ltr_i  input  NREQ  requester k letter-mode flag
gnt_o  output  NREQ  one-hot grant; all zero when idle
in3_o  output  4  digit 3 nibble to driver
in2_o  output  4  digit 2 nibble
in1_o  output  4  digit 1 nibble
in0_o  output  4  digit 0 nibble
ltr_o  output  1  letter mode to driver
busy_o  output  1  high while any grant is active

Behaviour:
- Reset (async assert, sync release by clk domain): state IDLE, gnt_o=0, in3_o..in0_o=0, ltr_o=0, busy_o=0, rr pointer=0, dwell counter=0.
- States: IDLE, SHOW.
- Round-robin pick: the first k with req_i[k]=1, searching ptr, ptr+1, ... mod NREQ. On every grant, ptr <= winner+1 mod NREQ.
- IDLE: if any req_i is set at edge t, then at t+1: state SHOW, gnt_o=onehot(winner), busy_o=1, outputs = winner's data/ltr, counter=1. With no request, stay IDLE. Outputs keep their last value and gnt_o=0.
- SHOW, counter < HOLD_CYCLES: counter increments (saturates at HOLD_CYCLES).
  - Owner req high: outputs reload from the owner's data_i/ltr_i every cycle (1-cycle latency, live update).
  - Owner req low: outputs frozen at the last loaded value. The grant is kept until the dwell expires.
- SHOW, dwell expired (counter == HOLD_CYCLES):
  - Another requester high: rearbitrate over all requesters except the current owner. The new grant takes effect next cycle with no blank gap, and the counter resets to 1.
  - No other request, owner still requesting: keep grant and keep live-updating. Counter stays saturated, so a later request from another requester is granted on the next cycle.
  - No other request, owner dropped: next cycle go to IDLE, gnt_o=0, busy_o=0, outputs retained.
- Simultaneous events: expiry plus a new request in the same cycle is served that cycle. Owner drop plus another request at expiry gives a handoff, not IDLE. Grant changes and data loads from the new owner land in the same cycle.
- HOLD_CYCLES=1: every SHOW cycle counts as expired. Grants rotate every cycle while multiple requesters are active.
- Reset mid-SHOW: immediate return to reset values. The pointer also resets.
- gnt_o is always one-hot or zero. All outputs come directly from flops.

Decomposition:
- Package sev_seg_pkg holds:
  - typedef hex4_t (logic [3:0]);
  - typedef disp_word_t (struct of four hex4_t: d3, d2, d1, d0);
  - localparam DIGITS=4.
- One combinational sub-module, rr_pick (NREQ, inputs req/ptr/mask, outputs valid/onehot/index), is used for both the IDLE pick and the expiry rearbitration.

Test Plan (HOLD_CYCLES=4, NREQ=4):
- Reset check: assert rst mid-run -> same cycle gnt_o=0000, in*_o=0, ltr_o=0, busy_o=0; release, no req -> remains idle.
- Single request: req_i=0010, data1=16'hBEEF, ltr1=1 -> next cycle gnt_o=0010, in3..in0=B,E,E,F, ltr_o=1. Change data1 to 16'h1234 -> outputs 1,2,3,4 one cycle later.
- Dwell enforcement: req 0 granted with 16'hAAAA, req 2 raised 1 cycle later with 16'h5555 -> gnt stays 0001 for exactly 4 cycles, then 0100 with 5,5,5,5 and no gap cycle.
- Round-robin fairness: all req_i=1111 held for 20 cycles -> grant sequence 0001,0010,0100,1000,0001, each lasting 4 cycles.
- Early drop: owner 3 drops req after 1 cycle, no other req -> outputs frozen, gnt 1000 until dwell ends, then gnt 0000, busy 0, digits retained.
- Drop with handoff: owner 0 drops while req 1 is pending -> at expiry gnt 0010 directly, never IDLE.
